// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
// Module   : div_unit
// Purpose  : Multi-cycle radix-2 restoring integer divider for the MIPS
//            execute stage. It claims the DIV and DIVU ALU control codes,
//            holds the pipeline stalled while it iterates, and delivers the
//            quotient (LO) and remainder (HI) with a one-cycle strobe.
//
// Ports    :
//   clk          in   1      sole clock, rising edge
//   resetn       in   1      synchronous active-low reset
//   alucontrol_i in   8      E-stage ALU control code
//   a_i          in   WIDTH  dividend (rs, forwarded)
//   b_i          in   WIDTH  divisor  (rt, forwarded)
//   flush_i      in   1      annul the E-stage instruction
//   stall_o      out  1      stall request to the hazard unit
//   ready_o      out  1      result-valid strobe / HI-LO write enable
//   lo_o         out  WIDTH  quotient
//   hi_o         out  WIDTH  remainder
//
// Config   : define DIV_ZERO_FAST_EN to short-circuit divide-by-zero
//            (IDLE -> DONE in one cycle, lo = all ones, hi = raw a_i).
//            Without it a zero divisor runs the full iteration sequence.
//
// Revision : 1.0  initial release
// ============================================================================
module div_unit #(
  parameter int         WIDTH       = 32,
  // Codes emitted by the decode-stage ALU decoder (defines.vh values).
  parameter logic [7:0] EXE_DIV_OP  = 8'b0001_1010,
  parameter logic [7:0] EXE_DIVU_OP = 8'b0001_1011
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [7:0]       alucontrol_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic             ready_o,
  output logic [WIDTH-1:0] lo_o,
  output logic [WIDTH-1:0] hi_o
);

  localparam int              CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

`ifdef DIV_ZERO_FAST_EN
  localparam bit FAST_ZERO = 1'b1;
`else
  localparam bit FAST_ZERO = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic               sa;        // dividend was negative (signed op only)
  logic               sb;        // divisor was negative (signed op only)
  logic [WIDTH-1:0]   dvsr;      // divisor magnitude
  logic [WIDTH-1:0]   quo;       // dividend bits shifting out, quotient shifting in
  // The partial remainder is always strictly less than the divisor after a
  // restoring step, so its top (WIDTH-th) bit is always zero and is not
  // stored; it is re-created as the shifted-in MSB below.
  logic [WIDTH-1:0]   rem;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   lo_q;
  logic [WIDTH-1:0]   hi_q;
  logic               ready_q;

  // --------------------------------------------------------------------------
  // Start detection and operand conditioning
  // --------------------------------------------------------------------------
  logic             is_div;
  logic             is_divu;
  logic             start;
  logic             sgn;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  always_comb begin
    is_div  = (alucontrol_i == EXE_DIV_OP);
    is_divu = (alucontrol_i == EXE_DIVU_OP);
    start   = (is_div || is_divu) && !flush_i;
    sgn     = is_div;
    a_neg   = sgn & a_i[WIDTH-1];
    b_neg   = sgn & b_i[WIDTH-1];
    // Two's-complement negation of the most negative value maps to itself,
    // which is exactly its unsigned magnitude.
    a_mag   = a_neg ? (~a_i + 1'b1) : a_i;
    b_mag   = b_neg ? (~b_i + 1'b1) : b_i;
  end

  // --------------------------------------------------------------------------
  // One restoring iteration
  // --------------------------------------------------------------------------
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   trial;
  logic             trial_neg;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] quo_nx;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  always_comb begin
    rem_sh    = {rem, quo[WIDTH-1]};
    trial     = rem_sh - {1'b0, dvsr};
    trial_neg = trial[WIDTH];
    rem_nx    = trial_neg ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
    quo_nx    = {quo[WIDTH-2:0], ~trial_neg};
    // Sign correction applied to the values the final iteration produces,
    // so the result registers load in the same edge that enters DONE.
    quo_fix   = (sa ^ sb) ? (~quo_nx + 1'b1) : quo_nx;
    rem_fix   = sa ? (~rem_nx + 1'b1) : rem_nx;
  end

  // --------------------------------------------------------------------------
  // Control FSM and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= IDLE;
      sa      <= 1'b0;
      sb      <= 1'b0;
      dvsr    <= '0;
      quo     <= '0;
      rem     <= '0;
      cnt     <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      ready_q <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      if (flush_i) begin
        // Annulled instruction: drop the operation, keep the last result.
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              sa   <= a_neg;
              sb   <= b_neg;
              dvsr <= b_mag;
              quo  <= a_mag;
              rem  <= '0;
              cnt  <= '0;
              if (FAST_ZERO && (b_i == '0)) begin
                lo_q    <= '1;
                hi_q    <= a_i;
                ready_q <= 1'b1;
                state   <= DONE;
              end else begin
                state <= ON;
              end
            end
          end

          ON: begin
            rem <= rem_nx;
            quo <= quo_nx;
            cnt <= cnt + CNT_W'(1);
            if (cnt == LAST) begin
              lo_q    <= quo_fix;
              hi_q    <= rem_fix;
              ready_q <= 1'b1;
              state   <= DONE;
            end
          end

          DONE: begin
            state <= IDLE;
          end

          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stall request: asserted from the cycle the op is seen until the last
  // iteration; released in DONE so the instruction can leave E.
  // --------------------------------------------------------------------------
  always_comb begin
    stall_o = 1'b0;
    case (state)
      IDLE:    stall_o = start;
      ON:      stall_o = !flush_i;
      default: stall_o = 1'b0;
    endcase
  end

  assign ready_o = ready_q;
  assign lo_o    = lo_q;
  assign hi_o    = hi_q;

endmodule
`default_nettype wire
